// File: rtl/cellrv32_bus_arbiter.sv
// Two-host arbiter for the processor-internal bus: port A (data, r/w) and port B (fetch, read-only).
// Default build: fixed priority for A with a B starvation limit. Define CELLRV32_BUSARB_RR_EN for round-robin.
module cellrv32_bus_arbiter #(
  parameter int B_STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] a_addr_i,
  input  logic        a_rden_i,
  input  logic        a_wren_i,
  input  logic [3:0]  a_ben_i,
  input  logic [31:0] a_wdata_i,
  output logic [31:0] a_rdata_o,
  output logic        a_ack_o,
  output logic        a_err_o,
  input  logic [31:0] b_addr_i,
  input  logic        b_rden_i,
  output logic [31:0] b_rdata_o,
  output logic        b_ack_o,
  output logic        b_err_o,
  output logic [31:0] p_bus_addr_o,
  output logic        p_bus_rden_o,
  output logic        p_bus_wren_o,
  output logic [3:0]  p_bus_ben_o,
  output logic [31:0] p_bus_wdata_o,
  input  logic [31:0] p_bus_rdata_i,
  input  logic        p_bus_ack_i,
  input  logic        p_bus_err_i
);

  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

  state_t      state_q, state_d;
  logic        a_pend_q, b_pend_q;
  logic [31:0] a_addr_q, a_wdata_q, b_addr_q;
  logic [3:0]  a_ben_q;
  logic        a_we_q;
  logic        rden_p1, wren_p1;

  logic a_req, a_cap, b_cap, a_want, b_want, a_we_eff;
  logic grant_a, grant_b, done, busy_a, busy_b, tie_b;

  assign a_req    = a_rden_i | a_wren_i;
  assign a_cap    = a_req & ~a_pend_q;
  assign b_cap    = b_rden_i & ~b_pend_q;
  assign a_want   = a_pend_q | a_req;
  assign b_want   = b_pend_q | b_rden_i;
  assign a_we_eff = a_pend_q ? a_we_q : a_wren_i;
  assign busy_a   = (state_q == BUSY_A);
  assign busy_b   = (state_q == BUSY_B);
  assign done     = (busy_a | busy_b) & (p_bus_ack_i | p_bus_err_i);

`ifdef CELLRV32_BUSARB_RR_EN
  // last_b_q = 1 means B received the most recent grant
  logic last_b_q;
  assign tie_b = ~last_b_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_b_q <= 1'b1;
    end else if (grant_a | grant_b) begin
      last_b_q <= grant_b;
    end
  end
`else
  localparam int CNT_W = (B_STARVE_LIMIT > 0) ? $clog2(B_STARVE_LIMIT + 1) : 1;
  logic [CNT_W-1:0] starve_cnt_q;
  assign tie_b = (B_STARVE_LIMIT != 0) && (starve_cnt_q == CNT_W'(B_STARVE_LIMIT));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_cnt_q <= '0;
    end else if (grant_b) begin
      starve_cnt_q <= '0;
    end else if (grant_a && b_want && (B_STARVE_LIMIT != 0)) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (a_want && b_want) begin
          grant_b = tie_b;
          grant_a = ~tie_b;
        end else begin
          grant_a = a_want;
          grant_b = b_want;
        end
        if (grant_a) begin
          state_d = BUSY_A;
        end else if (grant_b) begin
          state_d = BUSY_B;
        end
      end
      BUSY_A, BUSY_B: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant edge: state, pending flags and the one-cycle device pulse
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      a_pend_q <= 1'b0;
      b_pend_q <= 1'b0;
      rden_p1  <= 1'b0;
      wren_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      rden_p1 <= (grant_a & ~a_we_eff) | grant_b;
      wren_p1 <= grant_a & a_we_eff;
      if (done && busy_a) begin
        a_pend_q <= 1'b0;
      end else if (a_cap) begin
        a_pend_q <= 1'b1;
      end
      if (done && busy_b) begin
        b_pend_q <= 1'b0;
      end else if (b_cap) begin
        b_pend_q <= 1'b1;
      end
    end
  end

  // Request buffers hold the first request until its pending flag clears
  always_ff @(posedge clk_i) begin
    if (a_cap) begin
      a_addr_q  <= a_addr_i;
      a_ben_q   <= a_ben_i;
      a_wdata_q <= a_wdata_i;
      a_we_q    <= a_wren_i;
    end
    if (b_cap) begin
      b_addr_q <= b_addr_i;
    end
  end

  assign p_bus_rden_o  = rden_p1;
  assign p_bus_wren_o  = wren_p1;
  assign p_bus_addr_o  = busy_a ? a_addr_q : (busy_b ? b_addr_q : 32'h0);
  assign p_bus_ben_o   = busy_a ? a_ben_q : (busy_b ? 4'hF : 4'h0);
  assign p_bus_wdata_o = busy_a ? a_wdata_q : 32'h0;

  // Error wins over acknowledge; only the granted host sees the response
  assign a_err_o   = busy_a & p_bus_err_i;
  assign a_ack_o   = busy_a & p_bus_ack_i & ~p_bus_err_i;
  assign a_rdata_o = a_ack_o ? p_bus_rdata_i : 32'h0;
  assign b_err_o   = busy_b & p_bus_err_i;
  assign b_ack_o   = busy_b & p_bus_ack_i & ~p_bus_err_i;
  assign b_rdata_o = b_ack_o ? p_bus_rdata_i : 32'h0;

endmodule
